// File: rtl/ds_mod_pkg.sv
// Shared types and constants for the multi-channel noise-shaping delta-sigma modulator.
package ds_mod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TAP,
        ST_DITHER,
        ST_OUT
    } state_t;

    // One feedback coefficient as up to two shifted terms sharing a sign.
    typedef struct packed {
        logic       neg;
        logic [1:0] sh_a;
        logic       use_b;
        logic [1:0] sh_b;
    } coef_t;

    localparam logic [31:0] LFSR_SEED = 32'h0012_3456;

    function automatic int out_bits_f(input int in_bits, input int frac_bits);
        return in_bits - frac_bits + 1;
    endfunction

    function automatic int ch_bits_f(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    // x^n + x^(n-1) + 1 is maximal for n = 22 (and 2,3,4,6,7,15).
    function automatic logic [31:0] lfsr_taps(input int bits);
        return 32'h3 << (bits - 2);
    endfunction

    // Binomial (1-z^-1)^N error-feedback coefficients, indexed by {N, k} in octal.
    function automatic coef_t coef_lookup(input logic [2:0] n, input logic [2:0] k);
        coef_t c;
        c = '{1'b0, 2'd0, 1'b0, 2'd0};
        case ({n, k})
            6'o11:   c = '{1'b0, 2'd0, 1'b0, 2'd0};
            6'o21:   c = '{1'b0, 2'd1, 1'b0, 2'd0};
            6'o22:   c = '{1'b1, 2'd0, 1'b0, 2'd0};
            6'o31:   c = '{1'b0, 2'd1, 1'b1, 2'd0};
            6'o32:   c = '{1'b1, 2'd1, 1'b1, 2'd0};
            6'o33:   c = '{1'b0, 2'd0, 1'b0, 2'd0};
            6'o41:   c = '{1'b0, 2'd2, 1'b0, 2'd0};
            6'o42:   c = '{1'b1, 2'd2, 1'b1, 2'd1};
            6'o43:   c = '{1'b0, 2'd2, 1'b0, 2'd0};
            6'o44:   c = '{1'b1, 2'd0, 1'b0, 2'd0};
            default: c = '{1'b0, 2'd0, 1'b0, 2'd0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ds_mod_if.sv
// Sample-in / result-out handshake bundle of the delta-sigma modulator.
interface ds_mod_if
    import ds_mod_pkg::*;
#(
    parameter int IN_BITS          = 16,
    parameter int FRAC_BITS        = 11,
    parameter int CH_BITS          = 2,
    parameter int SHIFT_COUNT_BITS = 4,
    parameter int OUT_BITS         = out_bits_f(IN_BITS, FRAC_BITS)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [CH_BITS-1:0]          in_chan;
    logic [IN_BITS-1:0]          u;
    logic [SHIFT_COUNT_BITS-1:0] u_rshift;
    logic [2:0]                  order;
    logic                        dither_en;
    logic                        force_err;
    logic [FRAC_BITS-1:0]        forced_err_value;
    logic                        out_valid;
    logic                        out_ready;
    logic [CH_BITS-1:0]          out_chan;
    logic [OUT_BITS-1:0]         y;
    logic                        sat;

    modport master (
        output in_valid, in_chan, u, u_rshift, order, dither_en, force_err, forced_err_value,
        output out_ready,
        input  in_ready, out_valid, out_chan, y, sat
    );

    modport slave (
        input  in_valid, in_chan, u, u_rshift, order, dither_en, force_err, forced_err_value,
        input  out_ready,
        output in_ready, out_valid, out_chan, y, sat
    );
endinterface

// File: rtl/ds_err_history.sv
// Per-channel quantisation error history; slot 1 is the newest error.
module ds_err_history
    import ds_mod_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_ORDER    = 4,
    parameter int FRAC_BITS    = 11,
    parameter int CH_BITS      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CH_BITS-1:0]          rd_chan,
    input  logic [2:0]                  rd_k,
    output logic signed [FRAC_BITS-1:0] rd_err,
    input  logic                        wr_en,
    input  logic [CH_BITS-1:0]          wr_chan,
    input  logic signed [FRAC_BITS-1:0] wr_err
);
    logic signed [FRAC_BITS-1:0] mem [NUM_CHANNELS][MAX_ORDER];

    always_comb begin
        rd_err = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int t = 0; t < MAX_ORDER; t++) begin
                if (CH_BITS'(c) == rd_chan && 3'(t + 1) == rd_k) rd_err = mem[c][t];
            end
        end
    end

    // NOTE: this store is built from flops, so a full reset is legal; a RAM macro could not be cleared this way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int t = 0; t < MAX_ORDER; t++) mem[c][t] <= '0;
            end
        end else if (wr_en) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (CH_BITS'(c) == wr_chan) begin
                    mem[c][0] <= wr_err;
                    for (int t = 1; t < MAX_ORDER; t++) mem[c][t] <= mem[c][t-1];
                end
            end
        end
    end
endmodule

// File: rtl/ds_mod_multichannel.sv
// Time-multiplexed multi-channel error-feedback delta-sigma modulator, run-time order 0..MAX_ORDER.
module ds_mod_multichannel
    import ds_mod_pkg::*;
#(
    parameter int IN_BITS          = 16,
    parameter int FRAC_BITS        = 11,
    parameter int NUM_CHANNELS     = 4,
    parameter int MAX_ORDER        = 4,
    parameter int SHIFT_COUNT_BITS = 4,
    parameter int LFSR_BITS        = 22,
    parameter int DITHER_BITS      = 4
) (
    input logic     clk,
    input logic     reset,
    ds_mod_if.slave bus
);
    localparam int OUT_BITS = out_bits_f(IN_BITS, FRAC_BITS);
    localparam int CH_BITS  = ch_bits_f(NUM_CHANNELS);
    localparam int V_BITS   = IN_BITS + 4;

    localparam logic [2:0]              N_MAX = 3'(MAX_ORDER);
    localparam logic [LFSR_BITS-1:0]    TAPS  = LFSR_BITS'(lfsr_taps(LFSR_BITS));
    localparam logic [LFSR_BITS-1:0]    SEED  = LFSR_BITS'(LFSR_SEED);
    localparam logic signed [V_BITS-1:0] HALF  = V_BITS'(1 << (FRAC_BITS - 1));
    localparam logic signed [V_BITS-1:0] E_MAX = V_BITS'((1 << (FRAC_BITS - 1)) - 1);
    localparam logic signed [V_BITS-1:0] E_MIN = V_BITS'(-(1 << (FRAC_BITS - 1)));
    localparam logic signed [V_BITS-1:0] Y_MAX = V_BITS'((1 << OUT_BITS) - 1);

    state_t                      state, state_nx;
    logic                        in_ready_r;
    logic [CH_BITS-1:0]          chan_r;
    logic [2:0]                  n_r, n_in, tap_k;
    logic                        dith_r, force_r;
    logic [FRAC_BITS-1:0]        fev_r;
    logic signed [V_BITS-1:0]    v_r, v_in, v_tap, v_dith, v_rnd, q, y_w, e_full;
    logic signed [V_BITS-1:0]    err_x, term_a, term_b;
    logic [OUT_BITS-1:0]         y_r, y_c;
    logic                        sat_r, sat_c;
    logic signed [FRAC_BITS-1:0] e_r, e_c, rd_err;
    logic [LFSR_BITS-1:0]        lfsr;
    logic                        accept, commit;
    coef_t                       coef;

    assign accept = (state == ST_IDLE) && in_ready_r && bus.in_valid;
    assign commit = (state == ST_OUT) && bus.out_ready;
    assign n_in   = (int'(bus.order) > MAX_ORDER) ? N_MAX : bus.order;
    assign v_in   = V_BITS'(bus.u >> bus.u_rshift);

    // Tap k adds c_k * e[k] as at most two shifted copies of the stored error.
    assign coef   = coef_lookup(n_r, tap_k);
    assign err_x  = V_BITS'(rd_err);
    assign term_a = err_x <<< coef.sh_a;
    assign term_b = coef.use_b ? (err_x <<< coef.sh_b) : '0;
    assign v_tap  = coef.neg ? (v_r - term_a - term_b) : (v_r + term_a + term_b);

    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        v_dith = v_r;
        if (dith_r) v_dith = v_r + V_BITS'($signed(lfsr[DITHER_BITS-1:0]));
        v_rnd = v_dith + HALF;
        q     = v_rnd >>> FRAC_BITS;
        sat_c = 1'b0;
        y_c   = q[OUT_BITS-1:0];
        if (q[V_BITS-1]) begin
            y_c   = '0;
            sat_c = 1'b1;
        end else if (q > Y_MAX) begin
            y_c   = Y_MAX[OUT_BITS-1:0];
            sat_c = 1'b1;
        end
        y_w    = $signed(V_BITS'(y_c)) <<< FRAC_BITS;
        e_full = v_dith - y_w;
        e_c    = e_full[FRAC_BITS-1:0];
        if (e_full > E_MAX) begin
            e_c   = E_MAX[FRAC_BITS-1:0];
            sat_c = 1'b1;
        end else if (e_full < E_MIN) begin
            e_c   = E_MIN[FRAC_BITS-1:0];
            sat_c = 1'b1;
        end
        if (force_r) e_c = fev_r;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = (n_in == 3'd0) ? ST_DITHER : ST_TAP;
            ST_TAP:    if (tap_k == n_r) state_nx = ST_DITHER;
            ST_DITHER: state_nx = ST_OUT;
            ST_OUT:    if (bus.out_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            in_ready_r <= 1'b0;
            chan_r     <= '0;
            n_r        <= '0;
            tap_k      <= '0;
            dith_r     <= 1'b0;
            force_r    <= 1'b0;
            fev_r      <= '0;
            v_r        <= '0;
            y_r        <= '0;
            sat_r      <= 1'b0;
            e_r        <= '0;
            lfsr       <= SEED;
        end else begin
            state      <= state_nx;
            in_ready_r <= (state_nx == ST_IDLE);
            if (accept) begin
                chan_r  <= bus.in_chan;
                n_r     <= n_in;
                dith_r  <= bus.dither_en;
                force_r <= bus.force_err;
                fev_r   <= bus.forced_err_value;
                v_r     <= v_in;
                tap_k   <= 3'd1;
            end
            if (state == ST_TAP) begin
                v_r   <= v_tap;
                tap_k <= tap_k + 3'd1;
            end
            // The LFSR advances once per sample here, after its low bits were used as dither.
            if (state == ST_DITHER) begin
                y_r   <= y_c;
                sat_r <= sat_c;
                e_r   <= e_c;
                lfsr  <= {lfsr[LFSR_BITS-2:0], ^(lfsr & TAPS)};
            end
        end
    end

    ds_err_history #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .MAX_ORDER   (MAX_ORDER),
        .FRAC_BITS   (FRAC_BITS),
        .CH_BITS     (CH_BITS)
    ) u_hist (
        .clk    (clk),
        .reset  (reset),
        .rd_chan(chan_r),
        .rd_k   (tap_k),
        .rd_err (rd_err),
        .wr_en  (commit),
        .wr_chan(chan_r),
        .wr_err (e_r)
    );

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = (state == ST_OUT);
    assign bus.out_chan  = chan_r;
    assign bus.y         = y_r;
    assign bus.sat       = sat_r;
endmodule

// File: tb/tb_ds_mod_multichannel.sv
// Directed scoreboard bench for ds_mod_multichannel with an integer reference model.
module tb_ds_mod_multichannel;
    localparam int IN_BITS = 16, FRAC_BITS = 11, NUM_CHANNELS = 4, MAX_ORDER = 4;
    localparam int SHIFT_COUNT_BITS = 4, LFSR_BITS = 22, DITHER_BITS = 4;
    localparam int OUT_BITS = 6, CH_BITS = 2;
    localparam int COEF [5][4] = '{'{0, 0, 0, 0}, '{1, 0, 0, 0}, '{2, -1, 0, 0},
                                   '{3, -3, 1, 0}, '{4, -6, 4, -1}};

    typedef struct {
        int chan;
        int y;
        int sat;
        int n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ds_mod_if #(
        .IN_BITS(IN_BITS), .FRAC_BITS(FRAC_BITS), .CH_BITS(CH_BITS),
        .SHIFT_COUNT_BITS(SHIFT_COUNT_BITS), .OUT_BITS(OUT_BITS)
    ) bus ();

    ds_mod_multichannel #(
        .IN_BITS(IN_BITS), .FRAC_BITS(FRAC_BITS), .NUM_CHANNELS(NUM_CHANNELS),
        .MAX_ORDER(MAX_ORDER), .SHIFT_COUNT_BITS(SHIFT_COUNT_BITS),
        .LFSR_BITS(LFSR_BITS), .DITHER_BITS(DITHER_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_vectors = 0;
    int          n_miscompares = 0;
    int          m_hist [NUM_CHANNELS][MAX_ORDER];
    logic [21:0] m_lfsr;
    exp_t        sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int k = 0; k < MAX_ORDER; k++) m_hist[c][k] = 0;
        m_lfsr = 22'h123456;
    endfunction

    // Reference: v = (u>>sh) + sum c_k e_k (+ dither), round, clamp, commit error.
    function automatic exp_t model(input int ch, input int u, input int sh, input int ord,
                                   input bit dith, input bit frc, input int fev);
        int   n, v, t, q, y, e, d;
        bit   sat;
        exp_t r;
        n = (ord > MAX_ORDER) ? MAX_ORDER : ord;
        v = u >> sh;
        for (int k = 0; k < n; k++) v += COEF[n][k] * m_hist[ch][k];
        if (dith) begin
            d = int'(m_lfsr[3:0]);
            if (d >= 8) d -= 16;
            v += d;
        end
        m_lfsr = {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
        t   = v + 1024;
        q   = (t >= 0) ? t / 2048 : -((2047 - t) / 2048);
        sat = 1'b0;
        y   = q;
        if (q < 0) begin y = 0; sat = 1'b1; end
        else if (q > 63) begin y = 63; sat = 1'b1; end
        e = v - y * 2048;
        if (e > 1023) begin e = 1023; sat = 1'b1; end
        else if (e < -1024) begin e = -1024; sat = 1'b1; end
        if (frc) e = fev;
        for (int k = MAX_ORDER - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
        m_hist[ch][0] = e;
        r.chan = ch;
        r.y    = y;
        r.sat  = int'(sat);
        r.n    = n;
        return r;
    endfunction

    // Inputs change right after edge T; out_valid is due right after edge T+N+2.
    task automatic send(input int ch, input int u, input int sh, input int ord, input bit dith,
                        input bit frc, input int fev, input int stall);
        exp_t ex;
        int   lat;
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_chan          = 2'(ch);
        bus.u                = 16'(u);
        bus.u_rshift         = 4'(sh);
        bus.order            = 3'(ord);
        bus.dither_en        = dith;
        bus.force_err        = frc;
        bus.forced_err_value = 11'(fev);
        bus.out_ready        = (stall == 0);
        bus.in_valid         = 1'b1;
        sb.push_back(model(ch, u, sh, ord, dith, frc, fev));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ex = sb.pop_front();
        check("latency", lat, ex.n + 2);
        check("y", bus.y, ex.y);
        check("sat", bus.sat, ex.sat);
        check("out_chan", bus.out_chan, ex.chan);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_y", bus.y, ex.y);
            check("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", bus.out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b1;
        bus.in_valid         = 1'b0;
        bus.in_chan          = '0;
        bus.u                = '0;
        bus.u_rshift         = '0;
        bus.order            = '0;
        bus.dither_en        = 1'b0;
        bus.force_err        = 1'b0;
        bus.forced_err_value = '0;
        bus.out_ready        = 1'b1;
        model_reset();
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_y", bus.y, 0);
        check("rst_sat", bus.sat, 0);
        check("rst_out_chan", bus.out_chan, 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready_clocked", bus.in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", bus.in_ready, 1);

        // First-order loop on a half-LSB input: y toggles 1,0,1,0.
        for (int i = 0; i < 4; i++) send(0, 1024, 0, 1, 0, 0, 0, 0);

        // Order 0 full scale, right shift, then an order-1 sample exposing the committed e=-1.
        send(2, 'hFFFF, 0, 0, 0, 0, 0, 0);
        send(2, 'hFFFF, 4, 0, 0, 0, 0, 0);
        send(2, 1024, 0, 1, 0, 0, 0, 0);

        // Forced error, then order 7 (treated as 4) saturates low, then the clamped error is seen.
        send(3, 0, 0, 4, 0, 1, -1024, 0);
        send(3, 0, 0, 7, 0, 0, 0, 0);
        send(3, 1024, 0, 1, 0, 0, 0, 0);

        // Interleaved channels keep separate histories.
        for (int i = 0; i < 3; i++) begin
            send(0, 1024, 0, 1, 0, 0, 0, 0);
            send(1, 0, 0, 1, 0, 0, 0, 0);
        end

        send(1, 1018, 0, 0, 1, 0, 0, 0);
        send(2, 20000, 0, 0, 0, 0, 0, 10);
        send(2, 1024, 0, 2, 0, 0, 0, 0);
        send(2, 20000, 0, 0, 0, 0, 0, 0);

        // Reset while in TAP discards the sample and restores history and LFSR.
        @(negedge clk);
        bus.in_chan   = 2'd3;
        bus.u         = 16'd3000;
        bus.order     = 3'd4;
        bus.dither_en = 1'b0;
        bus.force_err = 1'b0;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_y", bus.y, 0);
        check("abort_out_chan", bus.out_chan, 0);
        check("abort_in_ready", bus.in_ready, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        send(3, 0, 0, 4, 0, 0, 0, 0);
        send(0, 1018, 0, 0, 1, 0, 0, 0);
        send(1, 1024, 0, 1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
